// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch plus 16-entry double-buffered palette producing 4:4:4 RGB aligned with sync.
// Define VGA_TESTBARS_EN to replace the framebuffer fetch with eight 128-pixel palette bars.
module vga_pixel_fetch #(
  parameter int ADDR_W     = 16,
  parameter int FB_PIXELS  = 38400,
  parameter int RD_LATENCY = 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              blank_n_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [10:0]       pixel_h,
  input  logic [31:0]       pixel_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  input  logic              pal_we,
  input  logic [3:0]        pal_waddr,
  input  logic [11:0]       pal_wdata,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hs_out,
  output logic              vs_out,
  output logic              blank_n_out,
  output logic              frame_start
);

  localparam int LAST = RD_LATENCY;

  // Bit 0 is the stage-0 request; bit LAST lines up with mem_rd_data.
  logic [LAST:0] valid_pipe_reg;
  logic [LAST:0] vis_pipe_reg;
  logic [LAST:0] hs_pipe_reg;
  logic [LAST:0] vs_pipe_reg;

  logic        fetch_next;
  logic        vs_prev_reg;
  logic        commit;
  logic [3:0]  index;
  logic [11:0] pix;
  logic [11:0] active_q [16];
  logic        unused_bits;

`ifdef VGA_TESTBARS_EN
  logic [3:0] bar_pipe_reg [LAST+1];

  assign fetch_next = 1'b0;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i <= LAST; i++) bar_pipe_reg[i] <= 4'd0;
    end else begin
      bar_pipe_reg[0] <= {1'b0, pixel_h[9:7]};
      for (int i = 1; i <= LAST; i++) bar_pipe_reg[i] <= bar_pipe_reg[i-1];
    end
  end

  assign index = bar_pipe_reg[LAST];
`else
  localparam logic [31:0] FB_LIMIT = 32'(FB_PIXELS);

  assign fetch_next = blank_n_in && (pixel_addr < FB_LIMIT);
  // Off-framebuffer or unfetched pixels fall back to palette entry 0.
  assign index = valid_pipe_reg[LAST] ? mem_rd_data[3:0] : 4'd0;
`endif

  assign unused_bits = ^{mem_rd_data, pixel_h, pixel_addr, valid_pipe_reg};

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      mem_rd_en      <= 1'b0;
      mem_rd_addr    <= '0;
      valid_pipe_reg <= '0;
      vis_pipe_reg   <= '0;
      hs_pipe_reg    <= '0;
      vs_pipe_reg    <= '0;
    end else begin
      mem_rd_en <= fetch_next;
      if (fetch_next) mem_rd_addr <= pixel_addr[ADDR_W-1:0];
      valid_pipe_reg <= {valid_pipe_reg[LAST-1:0], fetch_next};
      vis_pipe_reg   <= {vis_pipe_reg[LAST-1:0], blank_n_in};
      hs_pipe_reg    <= {hs_pipe_reg[LAST-1:0], hs_in};
      vs_pipe_reg    <= {vs_pipe_reg[LAST-1:0], vs_in};
    end
  end

  assign commit = vs_in && !vs_prev_reg;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vs_prev_reg <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vs_prev_reg <= vs_in;
      frame_start <= commit;
    end
  end

  // Shadow takes writes any time; active only changes on commit, so a
  // write on the commit cycle is seen one frame later.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pal
      localparam logic [3:0] GREY = 4'(gi);
      logic [11:0] shadow_reg;
      logic [11:0] active_reg;

      always_ff @(posedge vga_clk) begin
        if (reset) begin
          shadow_reg <= {GREY, GREY, GREY};
          active_reg <= {GREY, GREY, GREY};
        end else begin
          if (commit) active_reg <= shadow_reg;
          if (pal_we && (pal_waddr == GREY)) shadow_reg <= pal_wdata;
        end
      end

      assign active_q[gi] = active_reg;
    end
  endgenerate

  assign pix = active_q[index];

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      red         <= 4'd0;
      green       <= 4'd0;
      blue        <= 4'd0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      blank_n_out <= 1'b0;
    end else begin
      {red, green, blue} <= vis_pipe_reg[LAST] ? pix : 12'd0;
      hs_out      <= hs_pipe_reg[LAST];
      vs_out      <= vs_pipe_reg[LAST];
      blank_n_out <= vis_pipe_reg[LAST];
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: four instances (RD_LATENCY 1..4) against a history-based model.
module tb_vga_pixel_fetch;

  localparam int NI = 4;
  localparam int FB = 38400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, blank_in, hs_i, vs_i, we;
  logic [10:0] ph;
  logic [31:0] addr;
  logic [3:0]  waddr;
  logic [11:0] wdata;

  logic [NI-1:0] en_w, hs_w, vs_w, bl_w, fs_w;
  logic [15:0]   raddr_w [NI];
  logic [7:0]    rdata_w [NI];
  logic [3:0]    r_w [NI], g_w [NI], b_w [NI];

  int n_cmp = 0;
  int n_bad = 0;

  // Framebuffer contents: upper nibble is junk the DUT must ignore.
  function automatic logic [7:0] fb_byte(input logic [31:0] a);
    return {a[7:4] ^ 4'hA, a[3:0] ^ a[11:8]};
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int RD = gi + 1;
      logic [7:0] mpipe [RD];

      vga_pixel_fetch #(.ADDR_W(16), .FB_PIXELS(FB), .RD_LATENCY(RD)) dut (
        .vga_clk(clk), .reset(rst), .blank_n_in(blank_in), .hs_in(hs_i), .vs_in(vs_i),
        .pixel_h(ph), .pixel_addr(addr), .mem_rd_en(en_w[gi]), .mem_rd_addr(raddr_w[gi]),
        .mem_rd_data(rdata_w[gi]), .pal_we(we), .pal_waddr(waddr), .pal_wdata(wdata),
        .red(r_w[gi]), .green(g_w[gi]), .blue(b_w[gi]), .hs_out(hs_w[gi]), .vs_out(vs_w[gi]),
        .blank_n_out(bl_w[gi]), .frame_start(fs_w[gi])
      );

      always @(posedge clk) begin
        mpipe[0] <= en_w[gi] ? fb_byte({16'd0, raddr_w[gi]}) : 8'($urandom);
        for (int k = 1; k < RD; k++) mpipe[k] <= mpipe[k-1];
      end
      assign rdata_w[gi] = mpipe[RD-1];
    end
  endgenerate

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [32:0] exp_v [NI];
  bit          model_ok = 1'b0;
  int          m_edge = 0;
  int          last_rst = 0;
  logic        h_hs [64], h_vs [64], h_bl [64];
  logic [31:0] h_ad [64];
  logic [10:0] h_ph [64];
  logic [11:0] sh_m [16], ac_m [16];
  logic        vsp_m;
  logic [15:0] hold_m;

  always @(posedge clk) begin : model
    logic        en_e, fs_e;
    logic [3:0]  idx;
    logic [7:0]  byte_v;
    logic [11:0] rgb;
    int          s, j;
    m_edge++;
    if (rst) begin
      last_rst = m_edge;
      model_ok = 1'b1;
      vsp_m    = 1'b0;
      hold_m   = 16'd0;
      for (int i = 0; i < 16; i++) begin
        sh_m[i] = {4'(i), 4'(i), 4'(i)};
        ac_m[i] = {4'(i), 4'(i), 4'(i)};
      end
      for (int n = 0; n < NI; n++) exp_v[n] = '0;
    end else if (model_ok) begin
      j = m_edge % 64;
      h_hs[j] = hs_i; h_vs[j] = vs_i; h_bl[j] = blank_in; h_ad[j] = addr; h_ph[j] = ph;
`ifdef VGA_TESTBARS_EN
      en_e = 1'b0;
`else
      en_e = blank_in && (addr < FB);
`endif
      if (en_e) hold_m = addr[15:0];
      fs_e  = vs_i && !vsp_m;
      vsp_m = vs_i;
      for (int n = 0; n < NI; n++) begin
        s = m_edge - (n + 3) + 1;
        if (s > last_rst) begin
          j = s % 64;
`ifdef VGA_TESTBARS_EN
          idx = {1'b0, h_ph[j][9:7]};
`else
          byte_v = fb_byte(h_ad[j]);
          idx = (h_ad[j] < FB) ? byte_v[3:0] : 4'd0;
`endif
          rgb = h_bl[j] ? ac_m[idx] : 12'd0;
          exp_v[n] = {en_e, hold_m, rgb, h_hs[j], h_vs[j], h_bl[j], fs_e};
        end else begin
          exp_v[n] = {en_e, hold_m, 12'd0, 3'b000, fs_e};
        end
      end
      if (fs_e) for (int i = 0; i < 16; i++) ac_m[i] = sh_m[i];
      if (we) sh_m[waddr] = wdata;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int n = 0; n < NI; n++)
        chk($sformatf("outputs_L%0d", n + 3),
            {en_w[n], raddr_w[n], r_w[n], g_w[n], b_w[n], hs_w[n], vs_w[n], bl_w[n], fs_w[n]},
            exp_v[n]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] rgb0();
    return {r_w[0], g_w[0], b_w[0]};
  endfunction

  task automatic show(input logic [31:0] a, input logic [11:0] want, input string name);
    blank_in = 1'b1; addr = a; step();
    blank_in = 1'b0; addr = 32'd0; step(); step();
    chk(name, 33'(rgb0()), 33'(want));
  endtask

  task automatic commit_frame(input string name);
    vs_i = 1'b1; step();
    chk(name, 33'(fs_w[0]), 33'd1);
    vs_i = 1'b0; step();
  endtask

  initial begin
    rst = 1'b1; blank_in = 1'b0; hs_i = 1'b0; vs_i = 1'b0; we = 1'b0;
    ph = 11'd0; addr = 32'd0; waddr = 4'd0; wdata = 12'd0;
    step(); step();
    for (int n = 0; n < NI; n++)
      chk($sformatf("reset_state_L%0d", n + 3),
          {en_w[n], raddr_w[n], r_w[n], g_w[n], b_w[n], hs_w[n], vs_w[n], bl_w[n], fs_w[n]}, 33'd0);
    rst = 1'b0;

`ifndef VGA_TESTBARS_EN
    // Three consecutive visible pixels, grey palette.
    blank_in = 1'b1; addr = 32'd10; step();
    chk("t1_rd_en", 33'(en_w[0]), 33'd1);
    chk("t1_addr10", 33'(raddr_w[0]), 33'd10);
    addr = 32'd11; step();
    chk("t1_addr11", 33'(raddr_w[0]), 33'd11);
    addr = 32'd12; step();
    chk("t1_addr12", 33'(raddr_w[0]), 33'd12);
    chk("t1_rgb_a", 33'(rgb0()), 33'h0AAA);
    chk("t1_blank_a", 33'(bl_w[0]), 33'd1);
    blank_in = 1'b0; addr = 32'd0; step();
    chk("t1_rgb_b", 33'(rgb0()), 33'h0BBB);
    step();
    chk("t1_rgb_c", 33'(rgb0()), 33'h0CCC);
    step();
    chk("t1_rgb_off", 33'(rgb0()), 33'd0);
    chk("t1_blank_off", 33'(bl_w[0]), 33'd0);

    // Mid-frame palette write is invisible until the commit.
    we = 1'b1; waddr = 4'd5; wdata = 12'hF00; step(); we = 1'b0;
    show(32'd5, 12'h555, "t3_before_commit");
    vs_i = 1'b1; step();
    chk("t3_frame_start", 33'(fs_w[0]), 33'd1);
    step();
    chk("t3_frame_start_once", 33'(fs_w[0]), 33'd0);
    vs_i = 1'b0; step();
    show(32'd5, 12'hF00, "t3_after_commit");

    // Write on the commit cycle lands one frame late.
    vs_i = 1'b1; we = 1'b1; waddr = 4'd3; wdata = 12'h0F0; step(); we = 1'b0;
    chk("t4_frame_start", 33'(fs_w[0]), 33'd1);
    vs_i = 1'b0; step();
    show(32'd3, 12'h333, "t4_same_frame");
    commit_frame("t4_commit2");
    show(32'd3, 12'h0F0, "t4_next_frame");

    // Off-framebuffer pixel shows entry 0 without a read.
    we = 1'b1; waddr = 4'd0; wdata = 12'hABC; step(); we = 1'b0;
    commit_frame("t5_commit");
    blank_in = 1'b1; addr = 32'd38400; step();
    chk("t5_no_read", 33'(en_w[0]), 33'd0);
    blank_in = 1'b0; addr = 32'd0; step(); step();
    chk("t5_rgb_entry0", 33'(rgb0()), 33'h0ABC);
`else
    blank_in = 1'b1; ph = 11'd300; step();
    chk("bars_no_read", 33'(en_w[0]), 33'd0);
    blank_in = 1'b0; step(); step();
    chk("bars_rgb", 33'(rgb0()), 33'h0222);
`endif

    // Reset with reads outstanding.
    blank_in = 1'b1; addr = 32'd7; step();
    addr = 32'd8; step();
    rst = 1'b1; step();
    for (int n = 0; n < NI; n++)
      chk($sformatf("t6_reset_L%0d", n + 3),
          {en_w[n], raddr_w[n], r_w[n], g_w[n], b_w[n], hs_w[n], vs_w[n], bl_w[n], fs_w[n]}, 33'd0);
    rst = 1'b0; blank_in = 1'b0; addr = 32'd0;
`ifndef VGA_TESTBARS_EN
    show(32'd5, 12'h555, "t6_grey_ramp");
`endif

    // Randomised traffic, including sync toggles, palette writes and resets.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 599) == 0);
      hs_i     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) vs_i = ~vs_i;
      blank_in = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0: addr = 32'd38400 + 32'($urandom_range(0, 300));
        1: addr = 32'd38399;
        2: addr = $urandom;
        default: addr = 32'($urandom_range(0, FB - 1));
      endcase
      ph    = 11'($urandom_range(0, 1279));
      we    = ($urandom_range(0, 4) == 0);
      waddr = 4'($urandom);
      wdata = 12'($urandom);
      step();
    end
    rst = 1'b0; we = 1'b0; blank_in = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    for (int c = 0; c < 10; c++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
